wb_arb: RTL

WB_ARB -- requirements
Module: wb_arb

---
 rtl/wb_defs.sv | 10 +
 rtl/wb_fifo2.sv | 96 +++++++++
 rtl/wb_arb.sv | 137 +++++++++++++
 3 files changed

// File: rtl/wb_defs.sv
// Shared widths and defaults for the writeback arbiter.
// Imported by wb_fifo2 and wb_arb.
package wb_defs;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
    localparam int STARVE_LIM_DEF = 4;

endpackage

// File: rtl/wb_fifo2.sv
// Load-return FIFO with per-entry valid bits.
// Entries whose rd matches kill_rd_i are invalidated but still occupy a slot.
module wb_fifo2
    import wb_defs::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [REG_ADDR_W-1:0] push_rd_i,
    input  logic [DATA_W-1:0]     push_data_i,
    input  logic                  pop_i,
    input  logic                  kill_i,
    input  logic [REG_ADDR_W-1:0] kill_rd_i,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [CW-1:0]         cnt_o,
    output logic [REG_ADDR_W-1:0] head_rd_o,
    output logic [DATA_W-1:0]     head_data_o,
    output logic                  head_live_o
);

    logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
    logic [DATA_W-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0]      r_live;
    logic [CW-1:0]         r_cnt;

    logic [REG_ADDR_W-1:0] w_rd   [DEPTH];
    logic [DATA_W-1:0]     w_data [DEPTH];
    logic [DEPTH-1:0]      w_live;
    logic [CW-1:0]         w_cnt;
    logic [CW-1:0]         w_wr;

    assign empty_o     = (r_cnt == '0);
    assign full_o      = (r_cnt == CW'(DEPTH));
    assign cnt_o       = r_cnt;
    assign head_rd_o   = r_rd[0];
    assign head_data_o = r_data[0];
    assign head_live_o = r_live[0];

    // Next state: shift on pop, apply kill, then append the push.
    always_comb begin
        w_cnt = r_cnt;
        if (push_i && !pop_i) begin
            w_cnt = r_cnt + CW'(1);
        end else if (!push_i && pop_i) begin
            w_cnt = r_cnt - CW'(1);
        end
        w_wr = pop_i ? (r_cnt - CW'(1)) : r_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            w_rd[i]   = r_rd[i];
            w_data[i] = r_data[i];
            w_live[i] = r_live[i];
        end
        if (pop_i) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_rd[i]   = r_rd[i+1];
                w_data[i] = r_data[i+1];
                w_live[i] = r_live[i+1];
            end
            w_live[DEPTH-1] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && (w_rd[i] == kill_rd_i)) begin
                w_live[i] = 1'b0;
            end
            if (push_i && (w_wr == CW'(i))) begin
                w_rd[i]   = push_rd_i;
                w_data[i] = push_data_i;
                w_live[i] = !(kill_i && (push_rd_i == kill_rd_i));
            end
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
            r_live <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= w_rd[i];
                r_data[i] <= w_data[i];
            end
            r_live <= w_live;
            r_cnt  <= w_cnt;
        end
    end

endmodule

// File: rtl/wb_arb.sv
// Register-file writeback arbiter: pipeline results vs. buffered late loads.
// Define WB_ARB_BYPASS_EN to write a load straight through when idle.
module wb_arb
    import wb_defs::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_vld_i,
    input  logic [REG_ADDR_W-1:0] pipe_rd_i,
    input  logic [DATA_W-1:0]     pipe_data_i,
    input  logic                  mem_vld_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic [DATA_W-1:0]     mem_data_i,
    output logic                  mem_rdy_o,
    output logic                  stall_o,
    output logic                  rf_we_o,
    output logic [REG_ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0]     rf_wdata_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic                  w_empty;
    logic                  w_full;
    logic [CW-1:0]         w_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [REG_ADDR_W-1:0] w_head_rd;
    logic [DATA_W-1:0]     w_head_data;
    logic                  w_head_live;
    logic                  w_drain;
    logic                  w_grant;
    logic                  w_byp;
    logic                  w_push;
    logic [SW-1:0]         r_starve;

    assign w_drain = !w_empty
                  && (!pipe_vld_i || w_full
                      || (r_starve == SW'(STARVE_LIM)));
    assign w_grant = pipe_vld_i && !w_drain;

`ifdef WB_ARB_BYPASS_EN
    assign w_byp = w_empty && !pipe_vld_i
                && mem_vld_i && mem_rdy_o;
`else
    assign w_byp = 1'b0;
`endif

    assign w_push  = mem_vld_i && mem_rdy_o && !w_byp;
    assign stall_o = rst_n && pipe_vld_i && w_drain;

    wb_fifo2 #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (w_push),
        .push_rd_i  (mem_rd_i),
        .push_data_i(mem_data_i),
        .pop_i      (w_drain),
        .kill_i     (w_grant),
        .kill_rd_i  (pipe_rd_i),
        .empty_o    (w_empty),
        .full_o     (w_full),
        .cnt_o      (w_cnt),
        .head_rd_o  (w_head_rd),
        .head_data_o(w_head_data),
        .head_live_o(w_head_live)
    );

    // Occupancy after this cycle's push/pop, for the ready flag.
    always_comb begin
        w_cnt_nxt = w_cnt;
        if (w_push && !w_drain) begin
            w_cnt_nxt = w_cnt + CW'(1);
        end else if (!w_push && w_drain) begin
            w_cnt_nxt = w_cnt - CW'(1);
        end
    end

    // Ready whenever a slot remains free next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdy_o <= 1'b1;
        end else begin
            mem_rdy_o <= (w_cnt_nxt < CW'(DEPTH));
        end
    end

    // Count pipeline grants made while a load waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_empty || w_drain) begin
            r_starve <= '0;
        end else if (r_starve != SW'(STARVE_LIM)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Register the single write port from the selected source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            unique case (1'b1)
                w_drain: begin
                    rf_we_o    <= w_head_live
                               && (w_head_rd != ZERO_REG);
                    rf_waddr_o <= w_head_rd;
                    rf_wdata_o <= w_head_data;
                end
                w_grant: begin
                    rf_we_o    <= (pipe_rd_i != ZERO_REG);
                    rf_waddr_o <= pipe_rd_i;
                    rf_wdata_o <= pipe_data_i;
                end
                w_byp: begin
                    rf_we_o    <= (mem_rd_i != ZERO_REG);
                    rf_waddr_o <= mem_rd_i;
                    rf_wdata_o <= mem_data_i;
                end
                default: begin
                    rf_we_o    <= 1'b0;
                    rf_waddr_o <= '0;
                    rf_wdata_o <= '0;
                end
            endcase
        end
    end

endmodule
